// File: rtl/weight_preloader.sv
// Weight FIFO consumer: mirrors FIFO occupancy, pops one matrix per request and shifts it
// into the PE shadow registers farthest row first, then strobes weight_swap.
// Optional: WEIGHT_PRELOADER_ROW_CLEAR_EN forces row_data to zero outside valid rows.
module weight_preloader #(
    parameter int WEIGHT_BW   = 8,
    parameter int NUM_PE_ROWS = 8,
    parameter int MATRIX_SIZE = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic                                         fifo_push,
    output logic                                         fifo_rd_en,
    input  logic [WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE-1:0] fifo_data,
    input  logic                                         start,
    output logic                                         busy,
    output logic [WEIGHT_BW*MATRIX_SIZE-1:0]             row_data,
    output logic                                         row_valid,
    output logic [$clog2(NUM_PE_ROWS)-1:0]               row_idx,
    output logic                                         weight_swap,
    output logic                                         done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]              fifo_level
);

    localparam int ROW_W = WEIGHT_BW * MATRIX_SIZE;
    localparam int IDX_W = $clog2(NUM_PE_ROWS);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(NUM_PE_ROWS - 1);

    typedef enum logic [2:0] {IDLE, POP, CAPTURE, SHIFT, SWAP} state_t;

    state_t                              state, state_nx;
    logic                                pending, pending_nx;
    logic [IDX_W-1:0]                    cnt;
    logic [IDX_W-1:0]                    cnt_dn;
    logic [NUM_PE_ROWS-1:0][ROW_W-1:0]   mat_buf;
    logic [NUM_PE_ROWS-1:0][ROW_W-1:0]   fifo_rows;
    logic [ROW_W-1:0]                    row_q;

    assign fifo_rows = fifo_data;
    assign cnt_dn    = cnt - 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        pending_nx  = pending | start;
        fifo_rd_en  = 1'b0;
        row_valid   = 1'b0;
        weight_swap = 1'b0;
        case (state)
            // A start arriving this cycle counts as pending so the pop begins next cycle.
            IDLE: begin
                if ((pending | start) && fifo_level != '0) begin
                    state_nx   = POP;
                    pending_nx = 1'b0;
                end
            end
            // The FIFO cannot push and pop together, so the pop yields to a push.
            POP: begin
                fifo_rd_en = !fifo_push;
                if (!fifo_push) state_nx = CAPTURE;
            end
            CAPTURE: state_nx = SHIFT;
            SHIFT: begin
                row_valid = 1'b1;
                if (cnt == '0) state_nx = SWAP;
            end
            SWAP: begin
                weight_swap = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign done    = weight_swap;
    assign busy    = pending | (state != IDLE);
    assign row_idx = cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pending    <= 1'b0;
            fifo_level <= '0;
            cnt        <= '0;
            mat_buf    <= '0;
            row_q      <= '0;
        end else begin
            pending <= pending_nx;
            if (fifo_rd_en)
                fifo_level <= fifo_level - 1'b1;
            else if (fifo_push && fifo_level < LVL_MAX)
                fifo_level <= fifo_level + 1'b1;
            // row_q is preloaded one cycle ahead so row_data is a plain register output.
            if (state == CAPTURE) begin
                mat_buf <= fifo_rows;
                cnt     <= ROW_LAST;
                row_q   <= fifo_rows[ROW_LAST];
            end else if (state == SHIFT && cnt != '0) begin
                cnt   <= cnt_dn;
                row_q <= mat_buf[cnt_dn];
            end
        end
    end

`ifdef WEIGHT_PRELOADER_ROW_CLEAR_EN
    assign row_data = row_valid ? row_q : '0;
`else
    assign row_data = row_q;
`endif

endmodule

// File: tb/tb_weight_preloader.sv
// Scoreboard bench for weight_preloader: a timeline model of load requests predicts pop,
// row and swap cycles; a separate monitor pops and compares what the DUT presents.
module tb_weight_preloader;

    localparam int NR = 8;
    localparam int RW = 64;
    localparam int MW = 512;

    typedef struct {
        int          cyc;
        logic [2:0]  idx;
        logic [63:0] data;
    } row_t;

    logic           clk = 1'b0;
    logic           rstn;
    logic           fifo_push;
    logic           fifo_rd_en;
    logic [MW-1:0]  fifo_data = '0;
    logic [MW-1:0]  fifo_wdata;
    logic           start;
    logic           busy;
    logic [RW-1:0]  row_data;
    logic           row_valid;
    logic [2:0]     row_idx;
    logic           weight_swap;
    logic           done;
    logic [2:0]     fifo_level;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit run   = 1'b0;

    weight_preloader dut (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_push  (fifo_push),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .start      (start),
        .busy       (busy),
        .row_data   (row_data),
        .row_valid  (row_valid),
        .row_idx    (row_idx),
        .weight_swap(weight_swap),
        .done       (done),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural weight FIFO: drop on full, data_out registered on read.
    logic [MW-1:0] fq[$];
    always @(posedge clk) begin
        if (!rstn) begin
            fq.delete();
            fifo_data <= '0;
        end else begin
            if (fifo_rd_en && fq.size() != 0) fifo_data <= fq.pop_front();
            if (fifo_push && fq.size() < 4) fq.push_back(fifo_wdata);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a load is a timeline anchored on the cycle the pop happens.
    int            m_level    = 0;
    bit            m_pend     = 1'b0;
    bit            m_in_pop   = 1'b0;
    int            m_free_cyc = 0;
    logic [MW-1:0] m_mats[$];
    row_t          rq[$];
    int            dq[$];
    int            sq[$];
    logic [3:0]    lq[$];

    always @(negedge clk) begin
        bit            idle_m, req, rd;
        logic [MW-1:0] mtx;
        row_t          ent;
        if (run) begin
            idle_m = !m_in_pop && (cyc >= m_free_cyc);
            lq.push_back({(m_pend || !idle_m), 3'(m_level)});
            rd = 1'b0;
            if (m_in_pop && !fifo_push) begin
                rd = 1'b1;
                dq.push_back(cyc);
                mtx = m_mats.pop_front();
                for (int k = NR - 1; k >= 0; k--) begin
                    ent.cyc  = cyc + 2 + (NR - 1 - k);
                    ent.idx  = 3'(k);
                    ent.data = mtx[k*RW +: RW];
                    rq.push_back(ent);
                end
                sq.push_back(cyc + NR + 2);
                m_free_cyc = cyc + NR + 3;
                m_in_pop   = 1'b0;
            end
            req = m_pend || start;
            if (idle_m && req && m_level > 0) begin
                m_in_pop = 1'b1;
                m_pend   = 1'b0;
            end else begin
                m_pend = req;
            end
            if (fifo_push && m_level < 4) begin
                m_level++;
                m_mats.push_back(fifo_wdata);
            end
            if (rd) m_level--;
            if (!rstn) begin
                m_level = 0; m_pend = 1'b0; m_in_pop = 1'b0; m_free_cyc = 0;
                m_mats.delete();
                while (rq.size() != 0 && rq[$].cyc > cyc) void'(rq.pop_back());
                while (sq.size() != 0 && sq[$] > cyc) void'(sq.pop_back());
                while (dq.size() != 0 && dq[$] > cyc) void'(dq.pop_back());
            end
        end
    end

    // Monitor: compares every cycle against whatever the model has queued for it.
    logic [63:0] exp_last = '0;
    always @(negedge clk) begin
        logic [3:0] lv;
        row_t       er;
        bit         e_rd, e_row, e_sw;
        if (run) begin
            #1;
            lv = lq.pop_front();
            chk("fifo_level", 64'(fifo_level), 64'(lv[2:0]));
            chk("busy", 64'(busy), 64'(lv[3]));
            e_rd  = dq.size() != 0 && dq[0] == cyc;
            e_row = rq.size() != 0 && rq[0].cyc == cyc;
            e_sw  = sq.size() != 0 && sq[0] == cyc;
            chk("fifo_rd_en", 64'(fifo_rd_en), 64'(e_rd));
            chk("row_valid", 64'(row_valid), 64'(e_row));
            chk("weight_swap", 64'(weight_swap), 64'(e_sw));
            chk("done", 64'(done), 64'(e_sw));
            if (e_rd) void'(dq.pop_front());
            if (e_sw) void'(sq.pop_front());
            if (e_row) begin
                er = rq.pop_front();
                chk("row_idx", 64'(row_idx), 64'(er.idx));
                chk("row_data", row_data, er.data);
                exp_last = er.data;
            end else begin
`ifdef WEIGHT_PRELOADER_ROW_CLEAR_EN
                chk("row_data_idle", row_data, 64'd0);
`else
                chk("row_data_idle", row_data, exp_last);
`endif
            end
            if (!rstn) exp_last = '0;
        end
    end

    task automatic step(input bit p, input bit s, input bit r, input logic [MW-1:0] d);
        fifo_push  = p;
        start      = s;
        rstn       = r;
        fifo_wdata = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [MW-1:0] rnd_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < MW / 32; i++) m[i*32 +: 32] = $urandom;
        return m;
    endfunction

    function automatic logic [MW-1:0] ramp_mat();
        logic [MW-1:0] m;
        for (int r = 0; r < NR; r++) m[r*RW +: RW] = {8{8'(r + 1)}};
        return m;
    endfunction

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b1, '0);
    endtask

    initial begin
        rstn = 1'b0; fifo_push = 1'b0; start = 1'b0; fifo_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        run = 1'b1;
        step(1'b0, 1'b0, 1'b0, '0);

        // Basic load with a ramp matrix.
        step(1'b1, 1'b0, 1'b1, ramp_mat());
        idle(1);
        step(1'b0, 1'b1, 1'b1, '0);
        idle(14);

        // Start on empty, push arrives later.
        step(1'b0, 1'b1, 1'b1, '0);
        idle(4);
        step(1'b1, 1'b0, 1'b1, rnd_mat());
        idle(15);

        // Push held high across POP for two cycles.
        step(1'b1, 1'b0, 1'b1, rnd_mat());
        idle(1);
        step(1'b0, 1'b1, 1'b1, '0);
        step(1'b1, 1'b0, 1'b1, rnd_mat());
        step(1'b1, 1'b0, 1'b1, rnd_mat());
        idle(14);
        step(1'b0, 1'b1, 1'b1, '0);
        idle(14);
        step(1'b0, 1'b1, 1'b1, '0);
        idle(14);

        // Saturate the level, back-to-back loads, third start dropped.
        repeat (5) step(1'b1, 1'b0, 1'b1, rnd_mat());
        step(1'b0, 1'b1, 1'b1, '0);
        idle(5);
        step(1'b0, 1'b1, 1'b1, '0);
        step(1'b0, 1'b1, 1'b1, '0);
        idle(30);

        // Reset while row 4 is on the bus.
        step(1'b0, 1'b1, 1'b1, '0);
        idle(5);
        step(1'b0, 1'b0, 1'b0, '0);
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 399) != 0, rnd_mat());
        idle(30);

        chk("drain", 64'(rq.size() + sq.size() + dq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/weight_preloader.md
# weight_preloader

Consumer end of the weight FIFO. Tracks the FIFO's occupancy from the push side, pops one full weight matrix on request, and shifts it row by row into the systolic array's shadow weight registers, farthest row first. It then issues a one-cycle swap strobe so the PEs commit the new weights. It sits between the weight FIFO output and the PE array's weight-load inputs.

## Interface
- WEIGHT_BW, 8, bits per weight
- NUM_PE_ROWS, 8, PE rows, which is also the number of rows shifted per matrix
- MATRIX_SIZE, 8, weights per row (PE columns)
- FIFO_DEPTH, 4, depth of the attached weight FIFO, used for level mirroring

Ports:
- clk  in  1  clock; all logic on the rising edge
- rstn  in  1  reset, synchronous, active-low
- fifo_push  in  1  copy of the FIFO's write_enable
- fifo_rd_en  out  1  FIFO read_enable; one-cycle pulse per matrix
- fifo_data  in  WEIGHT_BW*NUM_PE_ROWS*MATRIX_SIZE  FIFO data_out; row r occupies bits [(r+1)*MATRIX_SIZE*WEIGHT_BW-1 : r*MATRIX_SIZE*WEIGHT_BW]
- start  in  1  request to load one matrix (pulse)
- busy  out  1  high while a request is pending or in progress
- row_data  out  WEIGHT_BW*MATRIX_SIZE  row currently being shifted into the array
- row_valid  out  1  row_data is valid this cycle
- row_idx  out  $clog2(NUM_PE_ROWS)  destination row of row_data
- weight_swap  out  1  one-cycle commit strobe to the PEs
- done  out  1  one-cycle pulse, coincident with weight_swap
- fifo_level  out  $clog2(FIFO_DEPTH+1)  mirrored FIFO occupancy

## Operation
- **Level mirror**
  - Increments on fifo_push when fifo_level < FIFO_DEPTH. A push seen while fifo_level == FIFO_DEPTH is ignored, which matches the FIFO's drop-on-full behaviour.
  - Decrements on fifo_rd_en.
- **Pending flag**
  - start sets a one-deep pending flag.
  - start while pending is already set is dropped.
  - busy = pending | (state != IDLE).
- **FSM states:** IDLE, POP, CAPTURE, SHIFT, SWAP.
  - IDLE: pending && fifo_level != 0 → POP, and pending clears. With pending && fifo_level == 0, remain in IDLE and wait.
  - POP: fifo_rd_en = !fifo_push. Pop and push never share a cycle, because the FIFO mishandles simultaneous push and pop. If fifo_push is high, stay in POP; otherwise → CAPTURE.
  - CAPTURE: fifo_data is valid in this cycle and is latched into an internal matrix buffer. The row counter is loaded with NUM_PE_ROWS-1. → SHIFT.
  - SHIFT: row_valid = 1, row_idx = counter, row_data = buffer row[counter]. The counter decrements each cycle. After row 0 is emitted → SWAP.
  - SWAP: weight_swap = done = 1 for one cycle. → IDLE.
- start during POP/CAPTURE/SHIFT/SWAP sets pending. The next load begins from IDLE the cycle after SWAP.
- Reset (any state, including mid-SHIFT) returns to IDLE and clears the buffer, pending flag and level. No weight_swap is issued for an aborted load. rstn is shared with the FIFO, so the mirror stays consistent.

## Timing
- Reset values: fifo_rd_en 0, busy 0, row_data 0, row_valid 0, row_idx 0, weight_swap 0, done 0, fifo_level 0.
- With start at cycle 0, state IDLE and fifo_level ≥ 1 (no concurrent push):
  - cycle 1: POP, fifo_rd_en = 1
  - cycle 2: CAPTURE
  - cycles 3 … 3+NUM_PE_ROWS-1: row_valid, with row_idx counting NUM_PE_ROWS-1 down to 0
  - cycle 3+NUM_PE_ROWS: weight_swap/done
- Each fifo_push cycle that coincides with POP adds one cycle of latency.
- fifo_level reflects a push or pop on the cycle after the event. Push and pop in the same cycle cannot occur.
- All outputs are registered or decoded from registered state; there is no input-to-output combinational path except fifo_rd_en's dependence on fifo_push.

## Configuration
- WEIGHT_PRELOADER_ROW_CLEAR_EN
  - Defined: row_data is forced to 0 whenever row_valid = 0.
  - Undefined: row_data holds the last emitted row (row 0) until the next SHIFT.
  - Only row_data is affected; handshakes and timing are identical in both cases.

## Test plan
- **Basic load:** push one matrix with row r = all bytes r+1, then pulse start → fifo_rd_en at cycle 1; 8 row_valid cycles with row_idx 7…0 and row_data bytes 8…1; weight_swap/done at cycle 11; fifo_level 1→0.
- **Start on empty:** start with level 0 → busy=1, no fifo_rd_en. Push at cycle 5 → fifo_rd_en at cycle 7 (level visible at 6, POP at 7).
- **Push/pop collision:** level 1, start, and fifo_push held high during POP for 2 cycles → fifo_rd_en is delayed 2 cycles; fifo_level goes 1→2→3→2 with no underflow.
- **Full and back-to-back:** push 5 matrices (level saturates at 4), start at cycle 0 and again mid-SHIFT → two consecutive loads with a single IDLE cycle between them; level ends at 2. A third start while pending is dropped.
- **Reset mid-SHIFT:** rstn low during row_idx 4 → next cycle all outputs are at reset values, no weight_swap, and fifo_level = 0.
- **Macro check:** run with and without WEIGHT_PRELOADER_ROW_CLEAR_EN → row_data = 0 versus row 0's value after done.
